// File: rtl/pll_reset_seq.sv
// pll_reset_seq: timed PLL reset pulse, heartbeat lock supervisor and system reset release
module pll_reset_seq #(
    parameter int RST_CYCLES    = 24,
    parameter int SETTLE_CYCLES = 2400,
    parameter int HB_TIMEOUT    = 64,
    parameter int MIN_EDGES     = 16,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_W         = 16
) (
    input  logic       refclk,
    input  logic       reset,
    input  logic       pll_hb,
    input  logic       rearm,
    output logic       pll_reset,
    output logic       sys_rst,
    output logic       pll_ok,
    output logic       fault,
    output logic [1:0] retry_cnt
);
    localparam int EW = $clog2(MIN_EDGES + 1);
    typedef enum logic [2:0] {RST_PULSE, SETTLE, CHECK, RUN, FAULT} state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [EW-1:0]    edges_q, edges_d;
    logic [1:0]       retry_q, retry_d;
    logic [2:0]       hb_q;
    logic             hb_edge, timeout, fail;
    logic             pll_reset_q, pll_reset_d, sys_rst_q, sys_rst_d;
    logic             pll_ok_q, pll_ok_d, fault_q, fault_d;
    assign hb_edge   = hb_q[1] ^ hb_q[2];
    assign timeout   = cnt_q == CNT_W'(HB_TIMEOUT - 1) && !hb_edge;
    assign pll_reset = pll_reset_q;
    assign sys_rst   = sys_rst_q;
    assign pll_ok    = pll_ok_q;
    assign fault     = fault_q;
    assign retry_cnt = retry_q;
    always_ff @(posedge refclk) begin
        if (reset) begin
            state_q     <= RST_PULSE;
            cnt_q       <= '0;
            edges_q     <= '0;
            retry_q     <= '0;
            hb_q        <= '0;
            pll_reset_q <= 1'b1;
            sys_rst_q   <= 1'b1;
            pll_ok_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            edges_q     <= edges_d;
            retry_q     <= retry_d;
            hb_q        <= {hb_q[1:0], pll_hb};
            pll_reset_q <= pll_reset_d;
            sys_rst_q   <= sys_rst_d;
            pll_ok_q    <= pll_ok_d;
            fault_q     <= fault_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        edges_d = edges_q;
        retry_d = retry_q;
        fail    = 1'b0;
        case (state_q)
            RST_PULSE: if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                state_d = SETTLE;
                cnt_d   = '0;
            end
            SETTLE: if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                state_d = CHECK;
                cnt_d   = '0;
                edges_d = '0;
            end
            CHECK: if (hb_edge) begin
                cnt_d   = '0;
                edges_d = edges_q + EW'(1);
                if (edges_d == EW'(MIN_EDGES)) begin
                    state_d = RUN;
                    retry_d = '0;
                end
            end else begin
                fail = timeout;
            end
            RUN: if (hb_edge) cnt_d = '0;
                 else fail = timeout;
            default: cnt_d = '0;
        endcase
        if (fail) begin
            cnt_d   = '0;
            state_d = retry_q < 2'(MAX_RETRY) ? RST_PULSE : FAULT;
            retry_d = retry_q < 2'(MAX_RETRY) ? retry_q + 2'd1 : retry_q;
        end
        if (rearm) begin
            state_d = RST_PULSE;
            cnt_d   = '0;
            edges_d = '0;
            retry_d = '0;
        end
    end
    always_comb begin
        pll_reset_d = state_d == RST_PULSE || state_d == FAULT;
        sys_rst_d   = state_d != RUN;
        pll_ok_d    = state_d == RUN;
        fault_d     = state_d == FAULT;
    end
endmodule
